alu_writeback: RTL and testbench

Writeback stage that consumes the ALU result bus and is the sole owner of the architectural status register and stack pointer. It registers aluout1/aluout2/status/stack results and drives the register-file write port. MUL is sequenced as two register writes over two cycles, with a stall to the issue stage. The registered status register and stack pointer feed back into the ALU as its statusregin and stack_reg inputs.

---
 rtl/alu_writeback.sv | 165 ++++++++++++++++
 tb/tb_alu_writeback.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//   Writeback stage behind the ALU. It owns the architectural status register
//   and stack pointer, and it drives the register-file write port.
//
//   A MUL takes two register writes on consecutive cycles: the low half
//   (aluout1) goes to rd, then the high half (aluout2) goes to rd+1, which
//   wraps 7->0. While the high-half write is pending, stall is high and the
//   issue stage must hold. Any wb_valid presented during stall is ignored.
//
// Parameters
//   STATUS_RST  reset value of statusreg
//   STACK_RST   reset value of stack_reg
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   wb_valid        in   ALU outputs valid this cycle
//   encoded_opcode  in   [5:0] opcode of the instruction in writeback
//   rd_addr         in   [2:0] destination register
//   aluout1         in   [15:0] primary result / MUL low half
//   aluout2         in   [15:0] MUL high half
//   status_in       in   [7:0] status computed by the ALU
//   stack_in        in   [11:0] stack pointer computed by the ALU
//   reg_we          out  register-file write enable (registered)
//   reg_waddr       out  [2:0] write address (registered)
//   reg_wdata       out  [15:0] write data (registered)
//   statusreg       out  [7:0] architectural status, fed back to the ALU
//   statusreg_eff   out  [7:0] status seen by the next instruction
//   stack_reg       out  [11:0] architectural stack pointer, fed back to the ALU
//   stall           out  high while the MUL high-half write is pending
//
// Build option
//   WB_STATUS_FWD_EN  When this macro is defined, statusreg_eff forwards
//                     status_in combinationally whenever this cycle's accept
//                     will update statusreg. When it is undefined,
//                     statusreg_eff is simply statusreg.
// ---------------------------------------------------------------------------
module alu_writeback #(
  parameter logic [7:0]  STATUS_RST = 8'h00,
  parameter logic [11:0] STACK_RST  = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [5:0]  encoded_opcode,
  input  logic [2:0]  rd_addr,
  input  logic [15:0] aluout1,
  input  logic [15:0] aluout2,
  input  logic [7:0]  status_in,
  input  logic [11:0] stack_in,
  output logic        reg_we,
  output logic [2:0]  reg_waddr,
  output logic [15:0] reg_wdata,
  output logic [7:0]  statusreg,
  output logic [7:0]  statusreg_eff,
  output logic [11:0] stack_reg,
  output logic        stall
);

  typedef enum logic {IDLE, MUL_HI} state_t;

  state_t      state_q, state_d;
  logic        reg_we_q, reg_we_d;
  logic [2:0]  reg_waddr_q, reg_waddr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic [7:0]  statusreg_q, statusreg_d;
  logic [11:0] stack_q, stack_d;
  logic [15:0] hi_data_q, hi_data_d;
  logic [2:0]  hi_addr_q, hi_addr_d;

  logic is_wr, is_mul, is_ghost, is_flag, is_stk;
  logic accept, status_upd;

  // Opcode class decode.
  always_comb begin
    is_wr    = 1'b0;
    is_mul   = 1'b0;
    is_ghost = 1'b0;
    is_flag  = 1'b0;
    is_stk   = 1'b0;
    case (encoded_opcode)
      6'o06, 6'o07, 6'o10, 6'o11, 6'o15, 6'o16,
      6'o21, 6'o22, 6'o23, 6'o24, 6'o30,
      6'o35, 6'o36, 6'o37:                   is_wr    = 1'b1;
      6'o41:                                 is_mul   = 1'b1;
      6'o25, 6'o26:                          is_ghost = 1'b1;
      6'o44, 6'o46:                          is_stk   = 1'b1;
      default: is_flag = (encoded_opcode >= 6'b101001) &&
                         (encoded_opcode <= 6'b110110);
    endcase
  end

  assign accept     = wb_valid && (state_q == IDLE);
  assign status_upd = is_wr || is_mul || is_ghost || is_flag;

  always_comb begin
    state_d     = state_q;
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    statusreg_d = statusreg_q;
    stack_d     = stack_q;
    hi_data_d   = hi_data_q;
    hi_addr_d   = hi_addr_q;

    if (state_q == MUL_HI) begin
      // Second half of a MUL. The new wb_valid is ignored this cycle.
      reg_we_d    = 1'b1;
      reg_waddr_d = hi_addr_q;
      reg_wdata_d = hi_data_q;
      state_d     = IDLE;
    end else if (accept) begin
      if (status_upd) statusreg_d = status_in;
      if (is_stk)     stack_d     = stack_in;
      if (is_wr || is_mul) begin
        reg_we_d    = 1'b1;
        reg_waddr_d = rd_addr;
        reg_wdata_d = aluout1;
      end
      if (is_mul) begin
        hi_data_d = aluout2;
        hi_addr_d = rd_addr + 3'd1;   // 3-bit wrap: R7 high half lands in R0
        state_d   = MUL_HI;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= 3'd0;
      reg_wdata_q <= 16'd0;
      statusreg_q <= STATUS_RST;
      stack_q     <= STACK_RST;
      hi_data_q   <= 16'd0;
      hi_addr_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      statusreg_q <= statusreg_d;
      stack_q     <= stack_d;
      hi_data_q   <= hi_data_d;
      hi_addr_q   <= hi_addr_d;
    end
  end

  assign reg_we    = reg_we_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign statusreg = statusreg_q;
  assign stack_reg = stack_q;
  assign stall     = (state_q == MUL_HI);

`ifdef WB_STATUS_FWD_EN
  // Forward the incoming status so a back-to-back ADC/SBC sees the fresh carry.
  assign statusreg_eff = (accept && status_upd) ? status_in : statusreg_q;
`else
  assign statusreg_eff = statusreg_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [5:0]  encoded_opcode;
  logic [2:0]  rd_addr;
  logic [15:0] aluout1, aluout2;
  logic [7:0]  status_in;
  logic [11:0] stack_in;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic [7:0]  statusreg, statusreg_eff;
  logic [11:0] stack_reg;
  logic        stall;

  int n_chk  = 0;
  int n_fail = 0;

  alu_writeback dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid),
    .encoded_opcode(encoded_opcode), .rd_addr(rd_addr),
    .aluout1(aluout1), .aluout2(aluout2), .status_in(status_in),
    .stack_in(stack_in), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .statusreg(statusreg),
    .statusreg_eff(statusreg_eff), .stack_reg(stack_reg), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [5:0]  op;
    logic [2:0]  rd;
    logic [15:0] a1;
    logic [7:0]  st;
    logic [11:0] sk;
    logic        e_we;
    logic [2:0]  e_wa;
    logic [15:0] e_wd;
    logic [7:0]  e_sr;
    logic [11:0] e_sk;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [2:0] rd,
                       input logic [15:0] a1, input logic [15:0] a2,
                       input logic [7:0] st, input logic [11:0] sk);
    wb_valid = v; encoded_opcode = op; rd_addr = rd;
    aluout1 = a1; aluout2 = a2; status_in = st; stack_in = sk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[13];

  initial begin
    // Each vector is applied for one cycle; the expected values are those after the edge.
    vecs[0]  = '{1'b1, 6'b010001, 3'd3, 16'h1234, 8'h40, 12'h000, 1'b1, 3'd3, 16'h1234, 8'h40, 12'hFFF}; // ADD
    vecs[1]  = '{1'b1, 6'b000000, 3'd5, 16'hFFFF, 8'h99, 12'h000, 1'b0, 3'd3, 16'h1234, 8'h40, 12'hFFF}; // no-op
    vecs[2]  = '{1'b0, 6'b000110, 3'd1, 16'hAAAA, 8'h11, 12'h000, 1'b0, 3'd3, 16'h1234, 8'h40, 12'hFFF}; // not valid
    vecs[3]  = '{1'b1, 6'b101101, 3'd2, 16'hBBBB, 8'h04, 12'h000, 1'b0, 3'd3, 16'h1234, 8'h04, 12'hFFF}; // SEC
    vecs[4]  = '{1'b1, 6'b100110, 3'd2, 16'hBBBB, 8'h77, 12'h0FE, 1'b0, 3'd3, 16'h1234, 8'h04, 12'h0FE}; // RTN
    vecs[5]  = '{1'b1, 6'b010101, 3'd2, 16'hBBBB, 8'h81, 12'h111, 1'b0, 3'd3, 16'h1234, 8'h81, 12'h0FE}; // GHOST
    vecs[6]  = '{1'b1, 6'b001110, 3'd6, 16'hCAFE, 8'h02, 12'h111, 1'b1, 3'd6, 16'hCAFE, 8'h02, 12'h0FE}; // WR
    vecs[7]  = '{1'b1, 6'b011111, 3'd0, 16'h0001, 8'h03, 12'h111, 1'b1, 3'd0, 16'h0001, 8'h03, 12'h0FE}; // WR top
    vecs[8]  = '{1'b1, 6'b110110, 3'd4, 16'h0002, 8'h10, 12'h111, 1'b0, 3'd0, 16'h0001, 8'h10, 12'h0FE}; // FLAG top
    vecs[9]  = '{1'b1, 6'b100100, 3'd4, 16'h0002, 8'h66, 12'h123, 1'b0, 3'd0, 16'h0001, 8'h10, 12'h123}; // STK
    vecs[10] = '{1'b1, 6'b001010, 3'd4, 16'h0002, 8'hEE, 12'h222, 1'b0, 3'd0, 16'h0001, 8'h10, 12'h123}; // past WR range
    vecs[11] = '{1'b1, 6'b101000, 3'd4, 16'h0002, 8'hEE, 12'h222, 1'b0, 3'd0, 16'h0001, 8'h10, 12'h123}; // below FLAG
    vecs[12] = '{1'b1, 6'b000110, 3'd4, 16'h0444, 8'h05, 12'h222, 1'b1, 3'd4, 16'h0444, 8'h05, 12'h123}; // WR bottom

    reset = 1'b1;
    drive(1'b0, 6'd0, 3'd0, 16'd0, 16'd0, 8'd0, 12'd0);
    #2;
    chk("rst_we", {31'd0, reg_we}, 32'd0);
    chk("rst_sr", {24'd0, statusreg}, 32'h00);
    chk("rst_sk", {20'd0, stack_reg}, 32'hFFF);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    #10 reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].vld, vecs[i].op, vecs[i].rd, vecs[i].a1, 16'h0, vecs[i].st, vecs[i].sk);
      tick();
      chk($sformatf("v%0d_we", i), {31'd0, reg_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_wa", i), {29'd0, reg_waddr}, {29'd0, vecs[i].e_wa});
      chk($sformatf("v%0d_wd", i), {16'd0, reg_wdata}, {16'd0, vecs[i].e_wd});
      chk($sformatf("v%0d_sr", i), {24'd0, statusreg}, {24'd0, vecs[i].e_sr});
      chk($sformatf("v%0d_sk", i), {20'd0, stack_reg}, {20'd0, vecs[i].e_sk});
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
    end

    // MUL into R7: the high half wraps to R0, and an ADD offered during the stall is dropped.
    drive(1'b1, 6'b100001, 3'd7, 16'h5678, 16'h0012, 8'h3C, 12'h0);
    tick();
    chk("mul_lo_we", {31'd0, reg_we}, 32'd1);
    chk("mul_lo_wa", {29'd0, reg_waddr}, 32'd7);
    chk("mul_lo_wd", {16'd0, reg_wdata}, 32'h5678);
    chk("mul_sr", {24'd0, statusreg}, 32'h3C);
    chk("mul_stall", {31'd0, stall}, 32'd1);
    drive(1'b1, 6'b010001, 3'd2, 16'h9999, 16'h0, 8'h55, 12'h0);
    tick();
    chk("mul_hi_we", {31'd0, reg_we}, 32'd1);
    chk("mul_hi_wa", {29'd0, reg_waddr}, 32'd0);
    chk("mul_hi_wd", {16'd0, reg_wdata}, 32'h0012);
    chk("mul_hi_stall", {31'd0, stall}, 32'd0);
    chk("mul_ign_sr", {24'd0, statusreg}, 32'h3C);
    drive(1'b0, 6'd0, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0);
    tick();
    chk("mul_ign_we", {31'd0, reg_we}, 32'd0);
    chk("mul_ign_wd", {16'd0, reg_wdata}, 32'h0012);

    // Asynchronous reset mid-run, with statusreg = A5.
    drive(1'b1, 6'b101001, 3'd0, 16'h0, 16'h0, 8'hA5, 12'h0);
    tick();
    chk("pre_rst_sr", {24'd0, statusreg}, 32'hA5);
    drive(1'b0, 6'd0, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0);
    #1 reset = 1'b1;
    #1;
    chk("arst_sr", {24'd0, statusreg}, 32'h00);
    chk("arst_sk", {20'd0, stack_reg}, 32'hFFF);
    chk("arst_we", {31'd0, reg_we}, 32'd0);
    chk("arst_wd", {16'd0, reg_wdata}, 32'h0);
    #2 reset = 1'b0;
    tick();

    // Reset during MUL_HI discards the pending high-half write.
    drive(1'b1, 6'b100001, 3'd1, 16'h1111, 16'h2222, 8'h01, 12'h0);
    tick();
    chk("rmul_stall", {31'd0, stall}, 32'd1);
    chk("rmul_wa", {29'd0, reg_waddr}, 32'd1);
    drive(1'b0, 6'd0, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0);
    #1 reset = 1'b1;
    #1;
    chk("rmul_rst_stall", {31'd0, stall}, 32'd0);
    #2 reset = 1'b0;
    tick();
    chk("rmul_no_hi_we", {31'd0, reg_we}, 32'd0);
    chk("rmul_no_hi_wd", {16'd0, reg_wdata}, 32'h0);
    chk("rmul_idle", {31'd0, stall}, 32'd0);
    drive(1'b1, 6'b010001, 3'd5, 16'h5555, 16'h0, 8'h02, 12'h0);
    tick();
    chk("rmul_acc_we", {31'd0, reg_we}, 32'd1);
    chk("rmul_acc_wa", {29'd0, reg_waddr}, 32'd5);

    // Status forwarding.
    drive(1'b1, 6'b101010, 3'd0, 16'h0, 16'h0, 8'h11, 12'h0);
    tick();
    chk("fwd_pre_sr", {24'd0, statusreg}, 32'h11);
    drive(1'b1, 6'b010001, 3'd2, 16'h0BAD, 16'h0, 8'h20, 12'h0);
    #1;
`ifdef WB_STATUS_FWD_EN
    chk("fwd_eff_same", {24'd0, statusreg_eff}, 32'h20);
`else
    chk("fwd_eff_same", {24'd0, statusreg_eff}, 32'h11);
`endif
    tick();
    drive(1'b0, 6'd0, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0);
    #1;
    chk("fwd_sr_next", {24'd0, statusreg}, 32'h20);
    chk("fwd_eff_next", {24'd0, statusreg_eff}, 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
